// File: rtl/mux.sv
// 2:1 single-bit multiplexer: y = sel ? d1 : d0.
// Latency: combinational.
// Backpressure: none, pure logic.
module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_tree_pipelined.sv
// Pipelined N:1 word selector / bitwise OR reducer built from a tree of 2:1 muxes.
// Latency: LEVELS cycles from accepted input to out_valid, one result per cycle.
// Backpressure: whole pipeline stalls when out_valid && !out_ready; in_ready mirrors that.
module mux_tree_pipelined #(
  parameter  int WIDTH  = 8,
  parameter  int N      = 8,
  localparam int LEVELS = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [LEVELS-1:0]    in_sel,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
);

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  // Index k is the input of level k; index LEVELS is the final stage.
  logic [N*WIDTH-1:0]  lvl_dat  [LEVELS+1];
  logic [LEVELS-1:0]   lvl_sel  [LEVELS+1];
  logic                lvl_mode [LEVELS+1];
  logic                lvl_vld  [LEVELS+1];
  logic                adv;
  logic                unused_bits;

  assign lvl_dat[0]  = in_data;
  assign lvl_sel[0]  = in_sel;
  assign lvl_mode[0] = in_mode;
  assign lvl_vld[0]  = in_valid;

  assign out_valid = lvl_vld[LEVELS];
  assign out_data  = lvl_dat[LEVELS][WIDTH-1:0];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  assign unused_bits = ^{lvl_dat[LEVELS][N*WIDTH-1:WIDTH], lvl_sel[LEVELS], lvl_mode[LEVELS]};

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int PAIRS = N >> (k + 1);

    logic [N*WIDTH-1:0] nxt;
    logic [N*WIDTH-1:0] dat_q;
    logic [LEVELS-1:0]  sel_q;
    logic               mode_q;
    logic               vld_q;
    logic               or_mode;

    assign or_mode = (lvl_mode[k] == MODE_OR);

    for (genvar j = 0; j < PAIRS; j++) begin : g_node
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic lo;
        logic hi;
        assign lo = lvl_dat[k][(2*j)*WIDTH + b];
        assign hi = lvl_dat[k][(2*j+1)*WIDTH + b];
        // OR mode: a set lower bit forces 1, otherwise pass the upper bit.
        mux u_mux (
          .d0  (or_mode ? hi : lo),
          .d1  (or_mode ? 1'b1 : hi),
          .sel (or_mode ? lo : lvl_sel[k][k]),
          .y   (nxt[j*WIDTH + b])
        );
      end
    end

    assign nxt[N*WIDTH-1:PAIRS*WIDTH] = '0;

    always_ff @(posedge clk) begin
      if (!rst) begin
        dat_q  <= '0;
        sel_q  <= '0;
        mode_q <= MODE_SEL;
        vld_q  <= 1'b0;
      end else if (adv) begin
        dat_q  <= nxt;
        sel_q  <= lvl_sel[k];
        mode_q <= lvl_mode[k];
        vld_q  <= lvl_vld[k];
      end
    end

    assign lvl_dat[k+1]  = dat_q;
    assign lvl_sel[k+1]  = sel_q;
    assign lvl_mode[k+1] = mode_q;
    assign lvl_vld[k+1]  = vld_q;
  end

endmodule
